// File: rtl/prio_enc_scan.sv
// Registered priority encoder: captures a request vector and emits the highest
// set index (mode 0) or every set index in descending order (mode 1).
module prio_enc_scan #(
  parameter  int unsigned WIDTH = 16,
  localparam int unsigned IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_vec,
  input  logic             in_mode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             out_none,
  output logic             busy
);

  typedef enum logic {IDLE, EMIT} state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] pend_q, pend_d;
  logic             mode_q, mode_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic             last_q, last_d;
  logic             none_q, none_d;
  logic             rdy_q, rdy_d;
  logic             vld_q, vld_d;
  logic             busy_q, busy_d;

  // Highest set bit; scanning upward lets the top bit win.
  function automatic logic [IDX_W-1:0] top_idx(input logic [WIDTH-1:0] v);
    top_idx = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (v[i]) top_idx = IDX_W'(i);
    end
  endfunction

  function automatic logic at_most_one(input logic [WIDTH-1:0] v);
    at_most_one = ((v & (v - WIDTH'(1))) == '0);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      pend_q  <= '0;
      mode_q  <= 1'b0;
      idx_q   <= '0;
      last_q  <= 1'b0;
      none_q  <= 1'b0;
      rdy_q   <= 1'b1;
      vld_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      pend_q  <= pend_d;
      mode_q  <= mode_d;
      idx_q   <= idx_d;
      last_q  <= last_d;
      none_q  <= none_d;
      rdy_q   <= rdy_d;
      vld_q   <= vld_d;
      busy_q  <= busy_d;
    end
  end

  // Next beat is precomputed so every output comes straight from a flop.
  always_comb begin
    state_d = state_q;
    pend_d  = pend_q;
    mode_d  = mode_q;
    idx_d   = idx_q;
    last_d  = last_q;
    none_d  = none_q;
    rdy_d   = rdy_q;
    vld_d   = vld_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          state_d = EMIT;
          pend_d  = in_vec;
          mode_d  = in_mode;
          idx_d   = top_idx(in_vec);
          none_d  = (in_vec == '0);
          last_d  = !in_mode || at_most_one(in_vec);
          rdy_d   = 1'b0;
          vld_d   = 1'b1;
          busy_d  = 1'b1;
        end
      end
      EMIT: begin
        if (out_ready) begin
          if (last_q) begin
            state_d = IDLE;
            pend_d  = '0;
            mode_d  = 1'b0;
            idx_d   = '0;
            last_d  = 1'b0;
            none_d  = 1'b0;
            rdy_d   = 1'b1;
            vld_d   = 1'b0;
            busy_d  = 1'b0;
          end else begin
            pend_d = pend_q & ~(WIDTH'(1) << idx_q);
            idx_d  = top_idx(pend_d);
            last_d = !mode_q || at_most_one(pend_d);
          end
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign in_ready  = rdy_q;
  assign out_valid = vld_q;
  assign out_idx   = idx_q;
  assign out_last  = last_q;
  assign out_none  = none_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_prio_enc_scan.sv
// Directed bench for prio_enc_scan: a 16-bit and a 10-bit instance sharing clk/rst.
module tb_prio_enc_scan;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        in_valid, in_ready, in_mode, out_valid, out_ready, out_last, out_none, busy;
  logic [15:0] in_vec;
  logic [3:0]  out_idx;

  logic        in_valid10, in_ready10, in_mode10, out_valid10, out_ready10;
  logic        out_last10, out_none10, busy10;
  logic [9:0]  in_vec10;
  logic [3:0]  out_idx10;

  int n_tests = 0;
  int n_fail  = 0;

  prio_enc_scan #(.WIDTH(16)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_vec(in_vec), .in_mode(in_mode),
    .out_valid(out_valid), .out_ready(out_ready), .out_idx(out_idx),
    .out_last(out_last), .out_none(out_none), .busy(busy)
  );

  prio_enc_scan #(.WIDTH(10)) dut10 (
    .clk(clk), .rst(rst),
    .in_valid(in_valid10), .in_ready(in_ready10), .in_vec(in_vec10), .in_mode(in_mode10),
    .out_valid(out_valid10), .out_ready(out_ready10), .out_idx(out_idx10),
    .out_last(out_last10), .out_none(out_none10), .busy(busy10)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Presents one vector to the 16-bit instance for a single cycle.
  task automatic send(input logic [15:0] v, input logic m);
    check("send_in_ready", 32'(in_ready), 32'd1);
    in_vec   = v;
    in_mode  = m;
    in_valid = 1'b1;
    step();
    in_valid = 1'b0;
  endtask

  // Checks the current beat, then lets it transfer.
  task automatic beat(input string tag, input int idx, input logic last, input logic none);
    out_ready = 1'b1;
    check({tag, "_valid"}, 32'(out_valid), 32'd1);
    check({tag, "_busy"},  32'(busy),      32'd1);
    check({tag, "_idx"},   32'(out_idx),   32'(idx));
    check({tag, "_last"},  32'(out_last),  32'(last));
    check({tag, "_none"},  32'(out_none),  32'(none));
    step();
  endtask

  initial begin
    rst = 1'b1;
    in_valid = 1'b0; in_vec = '0; in_mode = 1'b0; out_ready = 1'b1;
    in_valid10 = 1'b0; in_vec10 = '0; in_mode10 = 1'b0; out_ready10 = 1'b1;
    step();
    check("rst_in_ready",  32'(in_ready),  32'd1);
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_busy",      32'(busy),      32'd0);
    check("rst_idx",       32'(out_idx),   32'd0);
    check("rst_last",      32'(out_last),  32'd0);
    check("rst_none",      32'(out_none),  32'd0);
    rst = 1'b0;
    step();

    // All-zero vector: single none beat
    send(16'h0000, 1'b0);
    check("zero_in_ready_busy", 32'(in_ready), 32'd0);
    beat("zero", 0, 1'b1, 1'b1);
    check("zero_in_ready_back", 32'(in_ready), 32'd1);
    check("zero_out_valid_off", 32'(out_valid), 32'd0);

    // Mode 0 emits only the top bit
    send(16'h8001, 1'b0);
    beat("m0", 15, 1'b1, 1'b0);
    check("m0_done_valid", 32'(out_valid), 32'd0);
    check("m0_done_busy",  32'(busy),      32'd0);

    // Mode 1 enumeration, back-to-back beats
    send(16'hA005, 1'b1);
    beat("a005_b0", 15, 1'b0, 1'b0);
    beat("a005_b1", 13, 1'b0, 1'b0);
    beat("a005_b2", 2,  1'b0, 1'b0);
    beat("a005_b3", 0,  1'b1, 1'b0);
    check("a005_busy_off", 32'(busy),     32'd0);
    check("a005_ready_on", 32'(in_ready), 32'd1);

    // Backpressure holds the beat; input changes are ignored while busy
    send(16'h0030, 1'b1);
    out_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      check("bp_valid", 32'(out_valid), 32'd1);
      check("bp_idx",   32'(out_idx),   32'd5);
      check("bp_last",  32'(out_last),  32'd0);
      in_vec = 16'hFFFF; in_mode = 1'b0; in_valid = 1'b1;
      step();
    end
    in_valid = 1'b0;
    beat("bp_b0", 5, 1'b0, 1'b0);
    beat("bp_b1", 4, 1'b1, 1'b0);
    step();
    check("bp_no_extra", 32'(out_valid), 32'd0);

    // Asynchronous reset mid-enumeration
    send(16'hFFFF, 1'b1);
    beat("ff_b0", 15, 1'b0, 1'b0);
    beat("ff_b1", 14, 1'b0, 1'b0);
    beat("ff_b2", 13, 1'b0, 1'b0);
    check("ff_pending_idx", 32'(out_idx), 32'd12);
    #1 rst = 1'b1;
    #1;
    check("arst_out_valid", 32'(out_valid), 32'd0);
    check("arst_in_ready",  32'(in_ready),  32'd1);
    check("arst_busy",      32'(busy),      32'd0);
    check("arst_idx",       32'(out_idx),   32'd0);
    step();
    rst = 1'b0;
    step();
    check("post_rst_idle", 32'(out_valid), 32'd0);
    send(16'h0002, 1'b1);
    beat("post_b0", 1, 1'b1, 1'b0);
    check("post_done", 32'(out_valid), 32'd0);

    // Non-power-of-two width: top index is WIDTH-1
    in_vec10 = 10'h200; in_mode10 = 1'b1; in_valid10 = 1'b1;
    step();
    in_valid10 = 1'b0;
    check("w10_valid", 32'(out_valid10), 32'd1);
    check("w10_idx",   32'(out_idx10),   32'd9);
    check("w10_last",  32'(out_last10),  32'd1);
    step();
    check("w10_done", 32'(out_valid10), 32'd0);
    in_vec10 = 10'h201; in_mode10 = 1'b1; in_valid10 = 1'b1;
    step();
    in_valid10 = 1'b0;
    check("w10b_idx0",  32'(out_idx10),  32'd9);
    check("w10b_last0", 32'(out_last10), 32'd0);
    step();
    check("w10b_idx1",  32'(out_idx10),  32'd0);
    check("w10b_last1", 32'(out_last10), 32'd1);
    step();
    check("w10b_done", 32'(out_valid10), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/prio_enc_scan.md
Name: prio_enc_scan

Overview:
- Parametrised, registered successor to the team's 16-bit combinational priority encoder.
- Captures a WIDTH-bit request vector over a valid/ready handshake.
- Emits the index of the highest set bit (mode 0), or every set bit in descending order, one index per accepted output beat (mode 1).
- Sits between input-pin capture logic and downstream consumers that need a decoded index stream rather than a single combinational code.

Parameters:
- WIDTH, 16, request vector width; legal range 2..256, power of two not required.
- IDX_W, clog2(WIDTH), derived localparam, width of the index output; not overridable.

Ports:
- clk  input  1  clock; all state updates on rising edge
- rst  input  1  reset, asynchronous, active-high; clears all state immediately on assertion
- in_valid  input  1  request vector present
- in_ready  output  1  block can accept a vector
- in_vec  input  WIDTH  request vector; bit WIDTH-1 has highest priority
- in_mode  input  1  0 = top index only, 1 = enumerate all set bits
- out_valid  output  1  out_idx/out_last/out_none valid
- out_ready  input  1  consumer accepts current beat
- out_idx  output  IDX_W  index of highest remaining set bit
- out_last  output  1  final beat for the captured vector
- out_none  output  1  captured vector was all-zero
- busy  output  1  high in EMIT state

Behaviour:
- Reset values while rst high:
  - state = IDLE; in_ready = 1; out_valid = 0; busy = 0.
  - out_idx = 0; out_last = 0; out_none = 0.
  - Internal pending vector and mode register = 0.
- Reset mid-operation: any partially enumerated vector is discarded; no further beats are emitted for it.
- FSM, two states:
  - IDLE: in_ready = 1, out_valid = 0. in_valid & in_ready captures in_vec into pending and in_mode into mode_r, then moves to EMIT.
  - EMIT: in_ready = 0, out_valid = 1, busy = 1. in_vec/in_mode are ignored while in_ready = 0.
- Latency: first beat is valid in the cycle after capture (1 cycle).
- Beat contents, all derived from registered state (no combinational in->out path):
  - out_idx = position of highest set bit of pending.
  - out_none = 1 iff pending == 0 at capture; then out_idx = 0 and out_last = 1. This replaces the legacy 8'hF0 "no bit" code.
  - out_last = 1 if mode_r = 0, or if pending has exactly one set bit, or if out_none.
- Handshake:
  - Beat transfers on out_valid & out_ready.
  - While out_valid & !out_ready, out_idx, out_last and out_none hold stable.
  - On a transfer with out_last = 0, clear bit out_idx of pending and stay in EMIT; the next index appears the following cycle (throughput 1 index/cycle).
  - On a transfer with out_last = 1, go to IDLE; in_ready rises the next cycle. No same-cycle turnaround.
- Mode 0: exactly one beat per vector (the highest set bit, or a none beat).
- Mode 1: popcount(in_vec) beats in strictly descending index order, or one none beat if in_vec = 0.
- Non-power-of-two WIDTH: out_idx never exceeds WIDTH-1.

Test Plan:
- WIDTH=16, reset, then in_vec=16'h0000, mode 0, out_ready=1 -> one beat: out_none=1, out_idx=0, out_last=1; in_ready high again 2 cycles after capture.
- in_vec=16'h8001, mode 0 -> single beat out_idx=15, out_last=1; bit 0 is never emitted.
- in_vec=16'hA005, mode 1, out_ready=1 -> beats 15, 13, 2, 0 on consecutive cycles; out_last only on idx 0; busy high for exactly 4 cycles.
- in_vec=16'h0030, mode 1, out_ready low for 3 cycles on the first beat -> out_idx=5 held stable for 3 cycles, then 5, 4 transfer; in_vec changes while in_ready=0 have no effect.
- in_vec=16'hFFFF, mode 1, assert rst after the 3rd transfer -> out_valid=0 and in_ready=1 in the same cycle as rst (asynchronous); after release, new vector 16'h0002 mode 1 yields a single beat idx 1, out_last=1.
- WIDTH=10 build, in_vec=10'h200, mode 1 -> out_idx=9, out_last=1; IDX_W=4.
